// File: rtl/i2s_wb_dma_pkg.sv
// -----------------------------------------------------------------------------
// i2s_wb_dma_pkg
// Shared definitions for the I2S Wishbone sample fetcher:
//   - dma_state_t      : fetch FSM state encoding (IDLE / BUS / HALT)
//   - WB_CTI_CLASSIC   : Wishbone cycle type used on every access
//   - WB_BTE_LINEAR    : Wishbone burst type used on every access
//   - idx_is_last()    : true when a ring index sits on the last buffer word
// -----------------------------------------------------------------------------
package i2s_wb_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_HALT = 2'd2
    } dma_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    // ">=" rather than "==" so an index left beyond a buffer that was
    // shrunk at run time still wraps back to the start of the ring.
    function automatic logic idx_is_last(input logic [15:0] idx,
                                         input logic [15:0] words);
        return (idx >= (words - 16'd1));
    endfunction

endpackage

// File: rtl/i2s_wb_dma_if.sv
// -----------------------------------------------------------------------------
// i2s_wb_dma_if
// Wishbone classic bus between the sample fetcher (master) and memory (slave).
// Signal names are seen from the master side.
//   wbm_adr_o  address         wbm_dat_i  read data
//   wbm_sel_o  byte selects    wbm_we_o   write enable
//   wbm_cyc_o  cycle           wbm_stb_o  strobe
//   wbm_cti_o  cycle type      wbm_bte_o  burst type
//   wbm_ack_i  acknowledge     wbm_err_i  bus error     wbm_rty_i  retry
// -----------------------------------------------------------------------------
interface i2s_wb_dma_if #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
) ();

    logic [WB_AW-1:0]   wbm_adr_o;
    logic [WB_DW-1:0]   wbm_dat_i;
    logic [WB_DW/8-1:0] wbm_sel_o;
    logic               wbm_we_o;
    logic               wbm_cyc_o;
    logic               wbm_stb_o;
    logic [2:0]         wbm_cti_o;
    logic [1:0]         wbm_bte_o;
    logic               wbm_ack_i;
    logic               wbm_err_i;
    logic               wbm_rty_i;

    modport master (
        output wbm_adr_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
               wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_adr_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
               wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

endinterface

// File: rtl/i2s_fifo.sv
// -----------------------------------------------------------------------------
// i2s_fifo
// First-word-fall-through sample FIFO, DEPTH = 2**FIFO_AW entries.
//   wb_clk   clock             rst      synchronous active-high reset
//   i_push   write i_data      i_pop    drop head (ignored when empty)
//   i_flush  empty the FIFO    o_data   head entry (0 when empty)
//   o_count  occupancy         o_empty  no entries held
// -----------------------------------------------------------------------------
module i2s_fifo #(
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 3
) (
    input  logic               wb_clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [WB_DW-1:0]   i_data,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [WB_DW-1:0]   o_data,
    output logic [FIFO_AW:0]   o_count,
    output logic               o_empty
);

    localparam int DEPTH = 2**FIFO_AW;

    logic [WB_DW-1:0]   r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_pop;
    logic               w_push;
    logic               w_full;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    // A full FIFO may still take a word when the head leaves in the same cycle.
    assign w_push  = i_push & (~w_full | w_pop);

    // Sample storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge wb_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking with reset/flush priority.
    always_ff @(posedge wb_clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/i2s_wb_dma.sv
// -----------------------------------------------------------------------------
// i2s_wb_dma
// Read-only Wishbone classic master that walks a ring buffer of audio samples
// in memory and feeds them to an I2S transmitter through a small FWFT FIFO.
//   wb_clk, rst        clock / synchronous active-high reset
//   enable             fetching permitted; low in IDLE resets ring and FIFO
//   base_addr          byte address of ring buffer (word aligned)
//   buf_words          ring length in words (0 = nothing fetched)
//   wbm                Wishbone master port (i2s_wb_dma_if.master)
//   sample_o           FIFO head sample
//   sample_valid_o     sample_o valid; popped when sample_ready_i also high
//   sample_ready_i     consumer ready
//   wrap_o             one-cycle pulse after the last ring word is fetched
//   err_o              sticky bus error; cleared by dropping enable
// -----------------------------------------------------------------------------
module i2s_wb_dma
    import i2s_wb_dma_pkg::*;
#(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 3
) (
    input  logic              wb_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [WB_AW-1:0]  base_addr,
    input  logic [15:0]       buf_words,
    i2s_wb_dma_if.master      wbm,
    output logic [WB_DW-1:0]  sample_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              wrap_o,
    output logic              err_o
);

    localparam int DEPTH = 2**FIFO_AW;

    dma_state_t        r_state;
    dma_state_t        w_state_nxt;
    logic [15:0]       r_idx;
    logic [15:0]       w_idx_nxt;
    logic              r_cyc;
    logic              w_cyc_nxt;
    logic [WB_AW-1:0]  r_adr;
    logic [WB_AW-1:0]  w_adr_nxt;
    logic              r_wrap;
    logic              w_wrap_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_discard;
    logic              w_discard_nxt;

    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_empty;
    logic [FIFO_AW:0]  w_count;
    logic [WB_DW-1:0]  w_head;
    logic              w_can_fetch;
    logic [WB_AW-1:0]  w_fetch_adr;

    // Only start a fetch when its word is guaranteed a free FIFO slot.
    assign w_can_fetch = enable && (buf_words != 16'd0) &&
                         (w_count <= (FIFO_AW+1)'(DEPTH - 1));
    // Natural WB_AW-bit arithmetic wraps the address modulo 2**WB_AW.
    assign w_fetch_adr = base_addr + (WB_AW'(r_idx) << 2);

    // Next-state and next-output decode for the fetch FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cyc_nxt     = r_cyc;
        w_adr_nxt     = r_adr;
        w_wrap_nxt    = 1'b0;
        w_err_nxt     = r_err;
        w_discard_nxt = r_discard;
        w_push        = 1'b0;
        w_flush       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!enable) begin
                    w_idx_nxt = 16'd0;
                    w_flush   = 1'b1;
                    w_err_nxt = 1'b0;
                end else if (w_can_fetch) begin
                    w_state_nxt   = ST_BUS;
                    w_cyc_nxt     = 1'b1;
                    w_adr_nxt     = w_fetch_adr;
                    w_discard_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUS: begin
                // Once enable has dropped, this transfer's data is unwanted
                // even if enable comes back before the slave answers.
                if (!enable) begin
                    w_discard_nxt = 1'b1;
                end else begin
                    w_discard_nxt = r_discard;
                end
                // err beats rty and ack; rty beats ack.
                if (wbm.wbm_err_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_HALT;
                end else if (wbm.wbm_rty_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (wbm.wbm_ack_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (enable && !r_discard) begin
                        w_push = 1'b1;
                        if (idx_is_last(r_idx, buf_words)) begin
                            w_idx_nxt  = 16'd0;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 16'd1;
                        end
                    end else begin
                        w_push = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_BUS;
                end
            end
            ST_HALT: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cyc_nxt   = 1'b0;
            end
        endcase
    end

    // FSM state and registered bus/status outputs.
    always_ff @(posedge wb_clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= 16'd0;
            r_cyc     <= 1'b0;
            r_adr     <= '0;
            r_wrap    <= 1'b0;
            r_err     <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cyc     <= w_cyc_nxt;
            r_adr     <= w_adr_nxt;
            r_wrap    <= w_wrap_nxt;
            r_err     <= w_err_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    assign w_pop = ~w_empty & sample_ready_i;

    i2s_fifo #(
        .WB_DW   (WB_DW),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .wb_clk  (wb_clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (wbm.wbm_dat_i),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign wbm.wbm_adr_o = r_adr;
    assign wbm.wbm_cyc_o = r_cyc;
    assign wbm.wbm_stb_o = r_cyc;
    assign wbm.wbm_we_o  = 1'b0;
    assign wbm.wbm_sel_o = '1;
    assign wbm.wbm_cti_o = WB_CTI_CLASSIC;
    assign wbm.wbm_bte_o = WB_BTE_LINEAR;

    assign sample_o       = w_head;
    assign sample_valid_o = ~w_empty;
    assign wrap_o         = r_wrap;
    assign err_o          = r_err;

endmodule

// File: tb/tb_i2s_wb_dma.sv
`timescale 1ns/1ps
module tb_i2s_wb_dma;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int FAW = 3;

    logic        wb_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] base_addr;
    logic [15:0] buf_words;
    logic [31:0] sample_o;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic        wrap_o;
    logic        err_o;

    i2s_wb_dma_if #(.WB_AW(AW), .WB_DW(DW)) wbm ();

    i2s_wb_dma #(.WB_AW(AW), .WB_DW(DW), .FIFO_AW(FAW)) dut (
        .wb_clk         (wb_clk),
        .rst            (rst),
        .enable         (enable),
        .base_addr      (base_addr),
        .buf_words      (buf_words),
        .wbm            (wbm),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .wrap_o         (wrap_o),
        .err_o          (err_o)
    );

    always #5 wb_clk = ~wb_clk;

    // Scoreboard and reference model state.
    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];          // words the FIFO should hold, head first
    logic [31:0] adr_log[$];    // address of every bus cycle started
    int unsigned exp_idx;       // ring word the next fetch must read
    logic        exp_wrap;
    logic        prev_cyc;
    int          fetches;
    int          wrap_cnt;
    int          wait_left;
    logic [31:0] hold_adr;
    int          cyc_len;
    int          last_len;
    bit          track;
    // Stimulus knobs.
    int          ready_pct;
    int          rty_pct;
    int          max_wait;
    bit          fixed_wait;
    bit          err_armed;
    logic [31:0] err_addr;
    bit          force_rty;
    int          force_pop;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        adr_log.delete();
        exp_idx   = 0;
        exp_wrap  = 1'b0;
        prev_cyc  = 1'b0;
        fetches   = 0;
        wrap_cnt  = 0;
        wait_left = 0;
        cyc_len   = 0;
        last_len  = 0;
        track     = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        sample_ready_i = 1'b0;
        wbm.wbm_ack_i = 1'b0;
        wbm.wbm_err_i = 1'b0;
        wbm.wbm_rty_i = 1'b0;
        wbm.wbm_dat_i = 32'd0;
        ready_pct = 100; rty_pct = 0; max_wait = 0; fixed_wait = 1'b0;
        err_armed = 1'b0; force_rty = 1'b0; force_pop = 0;
        @(negedge wb_clk);
        @(negedge wb_clk);
        check_val("rst_cyc",   wbm.wbm_cyc_o, 32'd0);
        check_val("rst_stb",   wbm.wbm_stb_o, 32'd0);
        check_val("rst_adr",   wbm.wbm_adr_o, 32'd0);
        check_val("rst_valid", sample_valid_o, 32'd0);
        check_val("rst_sample", sample_o, 32'd0);
        check_val("rst_wrap",  wrap_o, 32'd0);
        check_val("rst_err",   err_o, 32'd0);
        check_val("const_we",  wbm.wbm_we_o, 32'd0);
        check_val("const_sel", wbm.wbm_sel_o, 32'hF);
        check_val("const_cti", wbm.wbm_cti_o, 32'd0);
        check_val("const_bte", wbm.wbm_bte_o, 32'd0);
        rst = 1'b0;
        model_clear();
    endtask

    // One clock: observe/check at negedge, then drive slave and consumer.
    task automatic tick();
        bit          do_ack;
        bit          do_err;
        bit          do_rty;
        bit          rdy;
        bit          last;
        logic [31:0] d;
        logic [31:0] a;
        int unsigned words_m1;
        @(negedge wb_clk);
        a = wbm.wbm_adr_o;
        if (track) begin
            check_val("valid", sample_valid_o, (q.size() != 0) ? 32'd1 : 32'd0);
            if (q.size() != 0) check_val("sample", sample_o, q[0]);
            check_val("wrap", wrap_o, exp_wrap);
        end
        if (wrap_o) wrap_cnt++;
        exp_wrap = 1'b0;
        if (wbm.wbm_cyc_o && !prev_cyc) begin
            fetches++;
            adr_log.push_back(a);
            check_val("fetch_adr", a, base_addr + (exp_idx << 2));
            check_val("fetch_stb", wbm.wbm_stb_o, 32'd1);
            hold_adr  = a;
            cyc_len   = 0;
            wait_left = fixed_wait ? max_wait : int'($urandom_range(max_wait, 0));
        end else if (wbm.wbm_cyc_o) begin
            check_val("adr_hold", a, hold_adr);
        end
        if (wbm.wbm_cyc_o) cyc_len++;
        else if (prev_cyc) last_len = cyc_len;
        prev_cyc = wbm.wbm_cyc_o;

        do_ack = 1'b0; do_err = 1'b0; do_rty = 1'b0;
        d = $urandom;
        if (wbm.wbm_cyc_o) begin
            if (wait_left > 0) begin
                wait_left--;
            end else if (err_armed && a == err_addr) begin
                do_err = 1'b1; do_ack = (($urandom & 32'd1) == 32'd1); err_armed = 1'b0;
            end else if (force_rty || ($urandom_range(99, 0) < rty_pct)) begin
                do_rty = 1'b1; do_ack = (($urandom & 32'd1) == 32'd1); force_rty = 1'b0;
            end else begin
                do_ack = 1'b1;
            end
        end
        if (force_pop > 0) begin
            rdy = 1'b1; force_pop--;
        end else begin
            rdy = ($urandom_range(99, 0) < ready_pct);
        end
        if (track && rdy && q.size() != 0) void'(q.pop_front());
        if (do_ack && !do_err && !do_rty && enable && track) begin
            q.push_back(d);
            words_m1 = 32'(buf_words) - 32'd1;
            last     = (exp_idx >= words_m1);
            exp_idx  = last ? 0 : exp_idx + 1;
            exp_wrap = last;
        end
        wbm.wbm_ack_i  = do_ack;
        wbm.wbm_err_i  = do_err;
        wbm.wbm_rty_i  = do_rty;
        wbm.wbm_dat_i  = d;
        sample_ready_i = rdy;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_fetches(input int n, input int bound);
        int k;
        k = 0;
        while (fetches < n && k < bound) begin
            tick();
            k++;
        end
        if (fetches < n) check_val("timeout_fetch", fetches, n);
    endtask

    // Caller has cleared track and dropped enable; wait for the bus to go
    // quiet, then the ring restarts at word 0 with an empty FIFO.
    task automatic resync();
        int k;
        k = 0;
        run(4);
        while (wbm.wbm_cyc_o && k < 50) begin
            tick();
            k++;
        end
        run(3);
        check_val("flush_valid", sample_valid_o, 32'd0);
        q.delete();
        exp_idx  = 0;
        exp_wrap = 1'b0;
        track    = 1'b1;
    endtask

    initial begin
        int f;
        // Ring order and wrap pulse with a zero-wait slave.
        do_reset();
        base_addr = 32'h1000; buf_words = 16'd3; enable = 1'b1;
        run_fetches(4, 100);
        check_val("ring_a0", adr_log[0], 32'h1000);
        check_val("ring_a1", adr_log[1], 32'h1004);
        check_val("ring_a2", adr_log[2], 32'h1008);
        check_val("ring_a3", adr_log[3], 32'h1000);
        check_val("ring_wraps", wrap_cnt, 32'd1);

        // FIFO fill stops fetching; one pop buys exactly one more fetch.
        do_reset();
        base_addr = 32'h2000; buf_words = 16'd16; ready_pct = 0; max_wait = 2;
        enable = 1'b1;
        run(80);
        check_val("full_fetches", fetches, 32'd8);
        check_val("full_cyc", wbm.wbm_cyc_o, 32'd0);
        check_val("full_valid", sample_valid_o, 32'd1);
        force_pop = 1;
        run(40);
        check_val("pop_fetches", fetches, 32'd9);

        // Retry reissues the same address and stores nothing.
        do_reset();
        base_addr = 32'h1000; buf_words = 16'd4; ready_pct = 0; force_rty = 1'b1;
        enable = 1'b1;
        run_fetches(3, 100);
        check_val("rty_a0", adr_log[0], 32'h1000);
        check_val("rty_a1", adr_log[1], 32'h1000);
        check_val("rty_a2", adr_log[2], 32'h1004);

        // Bus error halts until enable is cycled.
        do_reset();
        base_addr = 32'h1000; buf_words = 16'd8; err_addr = 32'h1004; err_armed = 1'b1;
        enable = 1'b1;
        run_fetches(2, 100);
        run(3);
        check_val("err_set", err_o, 32'd1);
        f = fetches;
        run(20);
        check_val("halt_fetches", fetches, f);
        check_val("halt_cyc", wbm.wbm_cyc_o, 32'd0);
        track = 1'b0; enable = 1'b0;
        resync();
        check_val("err_clear", err_o, 32'd0);
        enable = 1'b1;
        run_fetches(f + 1, 100);
        check_val("err_refetch", adr_log[adr_log.size() - 1], 32'h1000);

        // Enable drop mid-transfer: cycle completes, data discarded, idx 0.
        do_reset();
        base_addr = 32'h1000; buf_words = 16'd4; ready_pct = 0;
        max_wait = 3; fixed_wait = 1'b1; enable = 1'b1;
        run_fetches(2, 100);
        track = 1'b0; enable = 1'b0;
        resync();
        check_val("drop_len", last_len, 32'd4);
        f = fetches;
        enable = 1'b1;
        run_fetches(f + 1, 100);
        check_val("drop_refetch", adr_log[adr_log.size() - 1], 32'h1000);

        // Reset in the middle of a bus cycle.
        do_reset();
        base_addr = 32'h3000; buf_words = 16'd4; ready_pct = 0; enable = 1'b1;
        run_fetches(2, 100);
        max_wait = 5; fixed_wait = 1'b1;
        run_fetches(3, 100);
        tick();
        check_val("pre_rst_cyc", wbm.wbm_cyc_o, 32'd1);
        rst = 1'b1;
        wbm.wbm_ack_i = 1'b0;
        @(negedge wb_clk);
        check_val("mid_rst_cyc",   wbm.wbm_cyc_o, 32'd0);
        check_val("mid_rst_stb",   wbm.wbm_stb_o, 32'd0);
        check_val("mid_rst_adr",   wbm.wbm_adr_o, 32'd0);
        check_val("mid_rst_valid", sample_valid_o, 32'd0);
        check_val("mid_rst_sample", sample_o, 32'd0);
        check_val("mid_rst_err",   err_o, 32'd0);

        // Empty ring: nothing is ever fetched.
        do_reset();
        base_addr = 32'h4000; buf_words = 16'd0; enable = 1'b1;
        run(30);
        check_val("zero_words", fetches, 32'd0);

        // Randomized rounds against the model, incl. address wrap and 1-word ring.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            base_addr = (r == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            buf_words = (r == 1) ? 16'd1 : 16'($urandom_range(9, 1));
            max_wait  = int'($urandom_range(3, 0));
            rty_pct   = 20;
            ready_pct = int'($urandom_range(90, 10));
            enable    = 1'b1;
            run(400);
            if (fetches == 0) check_val("rand_progress", fetches, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
